// File: rtl/zbt_pkg.sv
// Shared constants and types for the ZBT SRAM controller.
//   ADDR_BITS / DATA_BITS : default SRAM address and data widths
//   zbt_op_t              : one user operation {valid, we, addr, wdata}
//   DIR_RD / DIR_WR       : bus direction encoding (matches req_we)
//   RW_DRIVE / RW_TRI     : pad tristate-enable patterns (0 = drive, 1 = float)
package zbt_pkg;

    localparam int ADDR_BITS = 16;
    localparam int DATA_BITS = 36;

    typedef struct packed {
        logic                 valid;
        logic                 we;
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] wdata;
    } zbt_op_t;

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

    localparam logic [DATA_BITS-1:0] RW_DRIVE = '0;
    localparam logic [DATA_BITS-1:0] RW_TRI   = '1;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_GAP = 1'b1
    } turn_state_e;

endpackage

// File: rtl/zbt_op_pipe.sv
// Three-stage operation tracker following each accepted op through the
// ZBT data pipeline.
//   clk_i       : clock
//   clr_i       : synchronous clear (drops every in-flight op)
//   in_valid_i  : op accepted this cycle
//   in_we_i     : accepted op is a write
//   in_wdata_i  : write word of the accepted op
//   s2_*_o      : stage 2, the write-data slot
//   s3_*_o      : stage 3, the read-capture slot
module zbt_op_pipe
    import zbt_pkg::*;
#(
    parameter int DATA_BITS = zbt_pkg::DATA_BITS
) (
    input  logic                 clk_i,
    input  logic                 clr_i,
    input  logic                 in_valid_i,
    input  logic                 in_we_i,
    input  logic [DATA_BITS-1:0] in_wdata_i,
    output logic                 s2_valid_o,
    output logic                 s2_we_o,
    output logic [DATA_BITS-1:0] s2_wdata_o,
    output logic                 s3_valid_o,
    output logic                 s3_we_o
);

    logic                 s1_valid_q, s1_we_q;
    logic [DATA_BITS-1:0] s1_wdata_q;
    logic                 s2_valid_q, s2_we_q;
    logic [DATA_BITS-1:0] s2_wdata_q;
    logic                 s3_valid_q, s3_we_q;

    // Write words only advance with a valid write, so stage 2 keeps the last
    // written word; that is exactly the hold behaviour wanted on write_data.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            s1_valid_q <= 1'b0;
            s1_we_q    <= 1'b0;
            s1_wdata_q <= '0;
            s2_valid_q <= 1'b0;
            s2_we_q    <= 1'b0;
            s2_wdata_q <= '0;
            s3_valid_q <= 1'b0;
            s3_we_q    <= 1'b0;
        end else begin
            s1_valid_q <= in_valid_i;
            s1_we_q    <= in_valid_i & in_we_i;
            if (in_valid_i && in_we_i) begin
                s1_wdata_q <= in_wdata_i;
            end
            s2_valid_q <= s1_valid_q;
            s2_we_q    <= s1_we_q;
            if (s1_valid_q && s1_we_q) begin
                s2_wdata_q <= s1_wdata_q;
            end
            s3_valid_q <= s2_valid_q;
            s3_we_q    <= s2_we_q;
        end
    end

    assign s2_valid_o = s2_valid_q;
    assign s2_we_o    = s2_we_q;
    assign s2_wdata_o = s2_wdata_q;
    assign s3_valid_o = s3_valid_q;
    assign s3_we_o    = s3_we_q;

endmodule

// File: rtl/zbt_sram_ctrl.sv
// Pipelined ZBT SRAM controller (FPGA side).
//
// state | meaning
// RUN   | accepting; a request in the other direction starts a turnaround
// GAP   | bus turnaround; ready low until the counter reaches 0, then the
//       | pending direction is accepted
//
// Ports:
//   fpga_clk, reset          : clock, synchronous active-high reset
//   req_valid/ready/we/addr/wdata : user request handshake
//   rd_valid, rd_data        : read return, 3 cycles after accept, in order
//   sram_addr/ce_n/we_n      : registered SRAM control pins
//   write_data, rw_tff       : pad buffer I and T inputs
//   read_data                : pad buffer O outputs
module zbt_sram_ctrl
    import zbt_pkg::*;
#(
    parameter int ADDR_BITS = zbt_pkg::ADDR_BITS,
    parameter int DATA_BITS = zbt_pkg::DATA_BITS,
    parameter int TURN_GAP  = 1
) (
    input  logic                 fpga_clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [DATA_BITS-1:0] req_wdata,
    output logic                 rd_valid,
    output logic [DATA_BITS-1:0] rd_data,
    output logic [ADDR_BITS-1:0] sram_addr,
    output logic                 sram_ce_n,
    output logic                 sram_we_n,
    output logic [DATA_BITS-1:0] write_data,
    output logic [DATA_BITS-1:0] rw_tff,
    input  logic [DATA_BITS-1:0] read_data
);

    localparam int CNT_W    = (TURN_GAP > 1) ? $clog2(TURN_GAP) : 1;
    localparam int GAP_LOAD = (TURN_GAP > 0) ? TURN_GAP - 1 : 0;

    localparam logic [DATA_BITS-1:0] TFF_DRIVE = {DATA_BITS{RW_DRIVE[0]}};
    localparam logic [DATA_BITS-1:0] TFF_TRI   = {DATA_BITS{RW_TRI[0]}};

    turn_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 last_dir_q, last_dir_d;
    logic                 pend_dir_q, pend_dir_d;
    logic                 gap_open, turn_needed, cur_dir, accept;

    logic [ADDR_BITS-1:0] sram_addr_q;
    logic                 sram_ce_n_q, sram_we_n_q;
    logic                 rd_valid_q;
    logic [DATA_BITS-1:0] rd_data_q;

    logic                 s2_valid, s2_we, s3_valid, s3_we;
    logic [DATA_BITS-1:0] s2_wdata;

    // The cycle that detects a direction change is itself the first idle bus
    // cycle, so GAP's final (count 0) cycle already accepts the pending
    // direction. This gives exactly TURN_GAP ready-low cycles per turnaround.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_dir_d = last_dir_q;
        pend_dir_d = pend_dir_q;

        gap_open    = (state_q == ST_RUN) || (cnt_q == '0);
        cur_dir     = (state_q == ST_GAP) ? pend_dir_q : last_dir_q;
        turn_needed = (TURN_GAP > 0) && req_valid && (req_we != cur_dir);

        if (state_q == ST_GAP) begin
            if (cnt_q == '0) begin
                state_d    = ST_RUN;
                last_dir_d = pend_dir_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        if (gap_open) begin
            if (turn_needed) begin
                state_d    = ST_GAP;
                cnt_d      = CNT_W'(GAP_LOAD);
                pend_dir_d = req_we;
            end else if (req_valid) begin
                last_dir_d = req_we;
            end
        end
    end

    assign req_ready = !reset && gap_open && !turn_needed;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge fpga_clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            last_dir_q  <= DIR_RD;
            pend_dir_q  <= DIR_RD;
            sram_addr_q <= '0;
            sram_ce_n_q <= 1'b1;
            sram_we_n_q <= 1'b1;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_dir_q  <= last_dir_d;
            pend_dir_q  <= pend_dir_d;
            sram_ce_n_q <= ~accept;
            sram_we_n_q <= ~(accept & req_we);
            if (accept) begin
                sram_addr_q <= req_addr;
            end
            rd_valid_q <= s3_valid & ~s3_we;
            if (s3_valid && !s3_we) begin
                rd_data_q <= read_data;
            end
        end
    end

    zbt_op_pipe #(
        .DATA_BITS (DATA_BITS)
    ) u_pipe (
        .clk_i      (fpga_clk),
        .clr_i      (reset),
        .in_valid_i (accept),
        .in_we_i    (req_we),
        .in_wdata_i (req_wdata),
        .s2_valid_o (s2_valid),
        .s2_we_o    (s2_we),
        .s2_wdata_o (s2_wdata),
        .s3_valid_o (s3_valid),
        .s3_we_o    (s3_we)
    );

    assign sram_addr  = sram_addr_q;
    assign sram_ce_n  = sram_ce_n_q;
    assign sram_we_n  = sram_we_n_q;
    assign write_data = s2_wdata;
    assign rw_tff     = (s2_valid && s2_we) ? TFF_DRIVE : TFF_TRI;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_zbt_sram_ctrl.sv
`timescale 1ns/1ps
module tb_zbt_sram_ctrl;
    import zbt_pkg::*;

    localparam int AB  = ADDR_BITS;
    localparam int DB  = DATA_BITS;
    localparam int GAP = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          req_valid, req_we, req_ready, rd_valid, sram_ce_n, sram_we_n;
    logic [AB-1:0] req_addr, sram_addr;
    logic [DB-1:0] req_wdata, rd_data, write_data, rw_tff, read_data;

    logic          v0, we0, rdy0, rdv0, ce0, wen0;
    logic [AB-1:0] a0, sa0;
    logic [DB-1:0] d0, rdd0, wd0, tf0, rdin0;

    zbt_sram_ctrl #(.ADDR_BITS(AB), .DATA_BITS(DB), .TURN_GAP(GAP)) u_dut (
        .fpga_clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rd_valid(rd_valid), .rd_data(rd_data), .sram_addr(sram_addr),
        .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .write_data(write_data),
        .rw_tff(rw_tff), .read_data(read_data));

    zbt_sram_ctrl #(.ADDR_BITS(AB), .DATA_BITS(DB), .TURN_GAP(0)) u_dut0 (
        .fpga_clk(clk), .reset(reset), .req_valid(v0), .req_ready(rdy0),
        .req_we(we0), .req_addr(a0), .req_wdata(d0),
        .rd_valid(rdv0), .rd_data(rdd0), .sram_addr(sa0),
        .sram_ce_n(ce0), .sram_we_n(wen0), .write_data(wd0),
        .rw_tff(tf0), .read_data(rdin0));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;
    logic last_dir = DIR_RD;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DB-1:0] init_word(input logic [AB-1:0] a);
        return {4'h5, a, a};
    endfunction

    // Reference model: memory as seen in issue order, plus expectations per cycle.
    logic [DB-1:0] ref_mem[int];
    logic [DB-1:0] sram_mem[int];
    typedef struct { logic we; logic [AB-1:0] addr; } pin_exp_t;
    typedef struct { logic [DB-1:0] data; int due; } rd_exp_t;
    pin_exp_t      pin_exp[int];
    logic [DB-1:0] wd_exp[int];
    rd_exp_t       rdq[$];

    // SRAM behind the pad buffer: address phase in cycle c, dq in cycle c+2.
    typedef struct { logic v; logic we; logic [AB-1:0] addr; } ph_t;
    ph_t           phist[int];
    logic [DB-1:0] t_hist[int];
    logic [DB-1:0] d_hist[int];

    always @(negedge clk) begin
        logic [63:0] r64;
        ph_t p, o;
        p.v = !sram_ce_n; p.we = !sram_we_n; p.addr = sram_addr;
        phist[cyc] = p;
        t_hist[cyc] = rw_tff;
        d_hist[cyc] = write_data;
        r64 = {$urandom(), $urandom()};
        read_data = r64[DB-1:0];
        if (phist.exists(cyc - 2) && t_hist.exists(cyc - 1)) begin
            o = phist[cyc - 2];
            if (o.v === 1'b1 && o.we === 1'b1) begin
                if (t_hist[cyc - 1] === RW_DRIVE) sram_mem[int'(o.addr)] = d_hist[cyc - 1];
            end else if (o.v === 1'b1 && mon_en) begin
                chk("read_slot_tristate", 64'(t_hist[cyc - 1]), 64'(RW_TRI));
                read_data = sram_mem.exists(int'(o.addr)) ? sram_mem[int'(o.addr)] : init_word(o.addr);
            end
        end
        phist.delete(cyc - 4); t_hist.delete(cyc - 4); d_hist.delete(cyc - 4);
    end

    // Monitor: compares pins and read returns against queued expectations.
    always @(negedge clk) begin
        rd_exp_t e;
        if (mon_en) begin
            if (pin_exp.exists(cyc)) begin
                chk("sram_ce_n", 64'(sram_ce_n), 64'(0));
                chk("sram_we_n", 64'(sram_we_n), 64'(!pin_exp[cyc].we));
                chk("sram_addr", 64'(sram_addr), 64'(pin_exp[cyc].addr));
                pin_exp.delete(cyc);
            end else begin
                chk("sram_ce_n_idle", 64'(sram_ce_n), 64'(1));
            end
            if (wd_exp.exists(cyc)) begin
                chk("rw_tff_drive", 64'(rw_tff), 64'(RW_DRIVE));
                chk("write_data", 64'(write_data), 64'(wd_exp[cyc]));
                wd_exp.delete(cyc);
            end else begin
                chk("rw_tff_idle", 64'(rw_tff), 64'(RW_TRI));
            end
            if (rd_valid === 1'b1) begin
                if (rdq.size() == 0) begin
                    chk("rd_valid_unexpected", 64'(rd_valid), 64'(0));
                end else begin
                    e = rdq.pop_front();
                    chk("rd_latency", 64'(cyc), 64'(e.due));
                    chk("rd_data", 64'(rd_data), 64'(e.data));
                end
            end else if (rdq.size() > 0 && rdq[0].due <= cyc) begin
                chk("rd_valid_missing", 64'(rd_valid), 64'(1));
                void'(rdq.pop_front());
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance
    // with req_valid dropped, so consecutive calls are back-to-back.
    task automatic issue(input logic we, input logic [AB-1:0] a, input logic [DB-1:0] d,
                         output int acc_cyc);
        int waited, exp_wait;
        bit done;
        rd_exp_t e;
        pin_exp_t pe;
        waited = 0; done = 0; acc_cyc = -1;
        exp_wait = (GAP > 0 && we != last_dir) ? GAP : 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        while (!done) begin
            #1;
            if (req_ready === 1'b1) begin
                done = 1; acc_cyc = cyc + 1;
            end else begin
                waited++;
                if (waited > 16) begin
                    chk("accept_timeout", 64'(waited), 64'(exp_wait));
                    done = 1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        if (acc_cyc >= 0) begin
            chk("turn_wait", 64'(waited), 64'(exp_wait));
            last_dir = we;
            pe.we = we; pe.addr = a;
            pin_exp[acc_cyc] = pe;
            if (we) begin
                wd_exp[acc_cyc + 1] = d;
                ref_mem[int'(a)] = d;
            end else begin
                e.data = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
                e.due  = acc_cyc + 3;
                rdq.push_back(e);
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got cycle %0d required finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int ac, prev;
        logic [DB-1:0] cap;
        zbt_op_t op;

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        v0 = 1'b0; we0 = 1'b0; a0 = '0; d0 = '0; rdin0 = '0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 64'(req_ready), 64'(0));
        chk("reset_ce_n", 64'(sram_ce_n), 64'(1));
        chk("reset_we_n", 64'(sram_we_n), 64'(1));
        chk("reset_addr", 64'(sram_addr), 64'(0));
        chk("reset_write_data", 64'(write_data), 64'(0));
        chk("reset_rw_tff", 64'(rw_tff), 64'(RW_TRI));
        chk("reset_rd_valid", 64'(rd_valid), 64'(0));
        chk("reset_rd_data", 64'(rd_data), 64'(0));
        reset = 1'b0;
        #1 chk("ready_after_reset", 64'(req_ready), 64'(1));
        mon_en = 1'b1;

        // Single write (first write after reset pays the turnaround)
        issue(DIR_WR, 16'h0010, 36'h9_ABCD_1234, ac);
        // Read it back
        issue(DIR_RD, 16'h0010, '0, ac);
        repeat (3) @(negedge clk);

        // Four back-to-back reads
        issue(DIR_RD, 16'h0000, '0, prev);
        for (int i = 1; i < 4; i++) begin
            issue(DIR_RD, AB'(i), '0, ac);
            chk("b2b_accept_spacing", 64'(ac - prev), 64'(1));
            prev = ac;
        end
        repeat (4) @(negedge clk);

        // Alternating W,R,W
        issue(DIR_WR, 16'h0020, 36'h1_1111_2222, ac);
        issue(DIR_RD, 16'h0020, '0, ac);
        issue(DIR_WR, 16'h0021, 36'hE_DCBA_9876, ac);
        repeat (4) @(negedge clk);

        // Randomised traffic
        for (int i = 0; i < 200; i++) begin
            op.valid = 1'b1;
            op.we    = 1'($urandom_range(0, 1));
            op.addr  = AB'($urandom_range(0, 15));
            op.wdata = {4'($urandom_range(0, 15)), $urandom()};
            issue(op.we, op.addr, op.wdata, ac);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        for (int k = 0; k < 20 && rdq.size() > 0; k++) @(negedge clk);
        chk("drain_random", 64'(rdq.size()), 64'(0));

        // Zero-gap instance: write then read with no ready drop
        v0 = 1'b1; we0 = 1'b1; a0 = 16'h0022; d0 = 36'h3_C0DE_CAFE;
        #1 chk("g0_ready_write", 64'(rdy0), 64'(1));
        @(negedge clk);
        chk("g0_ce_n_write", 64'(ce0), 64'(0));
        chk("g0_we_n_write", 64'(wen0), 64'(0));
        we0 = 1'b0;
        #1 chk("g0_ready_read", 64'(rdy0), 64'(1));
        @(negedge clk);
        v0 = 1'b0;
        chk("g0_rw_tff", 64'(tf0), 64'(RW_DRIVE));
        chk("g0_write_data", 64'(wd0), 64'(36'h3_C0DE_CAFE));
        chk("g0_ce_n_read", 64'(ce0), 64'(0));
        chk("g0_we_n_read", 64'(wen0), 64'(1));
        cap = wd0;
        @(negedge clk);
        chk("g0_addr_hold", 64'(sa0), 64'(16'h0022));
        @(negedge clk);
        rdin0 = cap;
        chk("g0_rd_valid_early", 64'(rdv0), 64'(0));
        @(negedge clk);
        chk("g0_rd_valid", 64'(rdv0), 64'(1));
        chk("g0_rd_data", 64'(rdd0), 64'(36'h3_C0DE_CAFE));
        @(negedge clk);
        chk("g0_rd_valid_pulse", 64'(rdv0), 64'(0));

        // Reset one cycle after a read accept: the read must vanish
        repeat (4) @(negedge clk);
        issue(DIR_RD, 16'h0010, '0, ac);
        reset = 1'b1;
        rdq.delete();
        foreach (pin_exp[k]) if (k > cyc) pin_exp.delete(k);
        foreach (wd_exp[k]) if (k > cyc) wd_exp.delete(k);
        @(negedge clk);
        chk("rst_mid_rw_tff", 64'(rw_tff), 64'(RW_TRI));
        chk("rst_mid_ce_n", 64'(sram_ce_n), 64'(1));
        chk("rst_mid_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        last_dir = DIR_RD;
        repeat (5) @(negedge clk);

        // Recovery read after reset
        issue(DIR_RD, 16'h0010, '0, ac);
        for (int k = 0; k < 20 && rdq.size() > 0; k++) @(negedge clk);
        chk("drain_final", 64'(rdq.size()), 64'(0));
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
